// File: rtl/galaga_msg_pkg.sv
// rtl/galaga_msg_pkg.sv - message screen state encoding and text colours
// fade_chan exists only when MSG_FADE_EN is defined
package galaga_msg_pkg;

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_PLAY     = 3'd1,
    ST_BOSS     = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_WIN      = 3'd4
  } msg_state_t;

  localparam logic [23:0] COL_WHITE  = 24'hFF_FF_FF;
  localparam logic [23:0] COL_CYAN   = 24'h00_FF_FF;
  localparam logic [23:0] COL_RED    = 24'hFF_00_00;
  localparam logic [23:0] COL_YELLOW = 24'hFF_FF_00;

`ifdef MSG_FADE_EN
  // step 15 gives c*16>>4 = c, so the ramp ends at full intensity
  function automatic logic [7:0] fade_chan(input logic [7:0] c, input logic [3:0] step);
    logic [11:0] prod;
    prod = 12'(c) * (12'(step) + 12'd1);
    return prod[11:4];
  endfunction
`endif

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - vsync synchroniser and rising-edge pulse generator
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync_q1;
  logic sync_q2;
  logic edge_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q1 <= frame_clk;
      sync_q2 <= sync_q1;
      edge_q  <= sync_q2;
    end
  end

  assign frame_tick = sync_q2 & ~edge_q;

endmodule

// File: rtl/msg_screen_ctrl.sv
// rtl/msg_screen_ctrl.sv - message screen FSM, frame timers and text overlay mux
// Optional brightness ramp on BOSS/GAMEOVER/WIN entry: MSG_FADE_EN
module msg_screen_ctrl
  import galaga_msg_pkg::*;
#(
  parameter int BANNER_FRAMES  = 120,
  parameter int BLINK_FRAMES   = 30,
  parameter int END_FRAMES     = 300,
  parameter int LOCKOUT_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       boss_wave,
  input  logic       player_dead,
  input  logic       all_cleared,
  input  logic       is_galaga,
  input  logic       is_press_start,
  input  logic       is_boss,
  input  logic       is_gameover,
  input  logic       is_you_win,
  output logic       overlay_on,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       game_run,
  output logic [2:0] msg_state
);

  localparam logic [8:0] BANNER_LAST = 9'(BANNER_FRAMES - 1);
  localparam logic [8:0] BLINK_LAST  = 9'(BLINK_FRAMES - 1);
  localparam logic [8:0] END_LAST    = 9'(END_FRAMES - 1);
  localparam logic [8:0] LOCKOUT_MIN = 9'(LOCKOUT_FRAMES);

  msg_state_t state, state_nxt;
  logic [8:0] frame_cnt;
  logic [8:0] blink_cnt;
  logic       blink_on;
  logic       frame_tick;
  logic       text_hit;
  logic [23:0] text_col;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= ST_TITLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_TITLE: if (start_key) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (player_dead)      state_nxt = ST_GAMEOVER;
        else if (all_cleared) state_nxt = ST_WIN;
        else if (boss_wave)   state_nxt = ST_BOSS;
      end
      ST_BOSS: begin
        if (player_dead)                                state_nxt = ST_GAMEOVER;
        else if (frame_tick && frame_cnt == BANNER_LAST) state_nxt = ST_PLAY;
      end
      ST_GAMEOVER, ST_WIN: begin
        if (start_key && frame_cnt >= LOCKOUT_MIN)    state_nxt = ST_TITLE;
        else if (frame_tick && frame_cnt == END_LAST) state_nxt = ST_TITLE;
      end
      default: state_nxt = ST_TITLE;
    endcase
  end

  // A state change always restarts the frame count, even on a tick cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_cnt <= 9'd0;
      blink_cnt <= 9'd0;
      blink_on  <= 1'b1;
    end else if (state_nxt != state) begin
      frame_cnt <= 9'd0;
      if (state_nxt == ST_TITLE) begin
        blink_cnt <= 9'd0;
        blink_on  <= 1'b1;
      end
    end else if (frame_tick) begin
      if (frame_cnt != 9'h1FF) frame_cnt <= frame_cnt + 9'd1;
      if (state == ST_TITLE) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= 9'd0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 9'd1;
        end
      end
    end
  end

  always_comb begin
    text_hit = 1'b0;
    text_col = 24'h0;
    case (state)
      ST_TITLE: begin
        if (is_galaga) begin
          text_hit = 1'b1;
          text_col = COL_WHITE;
        end else if (is_press_start && blink_on) begin
          text_hit = 1'b1;
          text_col = COL_CYAN;
        end
      end
      ST_BOSS:     begin text_hit = is_boss;     text_col = COL_RED;    end
      ST_GAMEOVER: begin text_hit = is_gameover; text_col = COL_RED;    end
      ST_WIN:      begin text_hit = is_you_win;  text_col = COL_YELLOW; end
      default:     begin text_hit = 1'b0;        text_col = 24'h0;      end
    endcase
`ifdef MSG_FADE_EN
    if (state != ST_TITLE && frame_cnt < 9'd16) begin
      text_col = {fade_chan(text_col[23:16], frame_cnt[3:0]),
                  fade_chan(text_col[15:8],  frame_cnt[3:0]),
                  fade_chan(text_col[7:0],   frame_cnt[3:0])};
    end
`endif
  end

  assign overlay_on = text_hit;
  assign Red        = text_hit ? text_col[23:16] : 8'h00;
  assign Green      = text_hit ? text_col[15:8]  : 8'h00;
  assign Blue       = text_hit ? text_col[7:0]   : 8'h00;
  assign game_run   = (state == ST_PLAY) || (state == ST_BOSS);
  assign msg_state  = state;

endmodule

// File: doc/msg_screen_ctrl.md
Name: msg_screen_ctrl

Overview:
- Downstream consumer of the logo pixel detectors (galaga, game-over, press-start, you-win, boss).
- Frame-counted state machine tracks which message screen is active, blinks the press-start text and times the boss banner.
- Gates the detector pixel flags into one overlay enable plus 8-bit RGB, combined by the colour mapper ahead of the VGA output.
- Also drives game_run, which tells the gameplay logic when to advance.

Parameters:
- BANNER_FRAMES, 120: frame ticks the boss banner stays up.
- BLINK_FRAMES, 30: frame ticks per press-start on/off phase.
- END_FRAMES, 300: frame ticks before game-over or win screen auto-returns to title.
- LOCKOUT_FRAMES, 60: frame ticks start_key is ignored after entering game-over or win.

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: synchronous reset, active-low.
- frame_clk, input, 1: VGA vertical sync, asynchronous to game logic.
- start_key, input, 1: start request, level.
- boss_wave, input, 1: boss wave begins, 1-cycle pulse.
- player_dead, input, 1: last life lost, 1-cycle pulse.
- all_cleared, input, 1: final wave cleared, 1-cycle pulse.
- is_galaga, is_press_start, is_boss, is_gameover, is_you_win: input, 1 each; detector pixel flags for the current DrawX/DrawY.
- overlay_on, output, 1: current pixel is message text.
- Red, Green, Blue: output, 8 each; text colour, 0 when overlay_on = 0.
- game_run, output, 1: gameplay may advance.
- msg_state, output, 3: current state, for debug and the colour mapper.

Behaviour:
- One clock domain (Clk). Reset is synchronous, active-low: Reset_n sampled low at a rising Clk edge forces reset, mid-operation included.
- Reset values: state = TITLE, frame_cnt = 0, blink_on = 1, sync flops = 0.
- Reset output values: game_run = 0, msg_state = TITLE. overlay_on and RGB follow the TITLE mapping.
- Frame tick:
  - frame_clk passes through 2 sync flops plus an edge register.
  - Rising edge gives frame_tick, high for 1 Clk.
  - Latency is 3 Clk from the frame_clk rise.
- frame_cnt: 9 bits, counts frame_tick, saturates at 511. Cleared on every state transition. When a transition and a tick coincide, the transition wins and frame_cnt = 0.
- States and transitions, all evaluated at the Clk edge:
  - TITLE: start_key = 1 -> PLAY.
  - PLAY: resolve by priority player_dead > all_cleared > boss_wave.
    - player_dead -> GAMEOVER.
    - all_cleared -> WIN.
    - boss_wave -> BOSS.
  - BOSS: player_dead -> GAMEOVER. Otherwise, on the frame_tick where frame_cnt == BANNER_FRAMES-1, -> PLAY (exactly BANNER_FRAMES ticks).
  - GAMEOVER and WIN:
    - start_key with frame_cnt >= LOCKOUT_FRAMES -> TITLE.
    - Otherwise, the tick where frame_cnt == END_FRAMES-1 -> TITLE.
    - start_key during lockout is ignored and not remembered.
- Pulse inputs in states that do not use them are dropped.
- Blink:
  - In TITLE, blink_on toggles on the tick where blink count == BLINK_FRAMES-1; that count then wraps to 0.
  - Entering TITLE sets blink_on = 1 and clears the blink count.
- Overlay mapping (combinational from registered state and flags, 0-cycle pixel latency):
  - TITLE: is_galaga | (is_press_start & blink_on). Galaga text white FF/FF/FF, press-start cyan 00/FF/FF.
  - BOSS: is_boss, red FF/00/00.
  - GAMEOVER: is_gameover, red FF/00/00.
  - WIN: is_you_win, yellow FF/FF/00.
  - PLAY: overlay_on = 0.
- game_run = 1 in PLAY and BOSS only.
- msg_state encoding: TITLE 0, PLAY 1, BOSS 2, GAMEOVER 3, WIN 4.

Optional Feature:
- Macro MSG_FADE_EN.
- Defined: during the first 16 frame ticks of BOSS, GAMEOVER and WIN, each RGB channel = (colour * (frame_cnt+1)) >> 4, reaching full intensity at frame_cnt = 15. TITLE is unaffected.
- Undefined: full intensity immediately; no multiplier is synthesised.

Decomposition:
- Package galaga_msg_pkg: msg_state_t enum (3-bit encoding above), 24-bit colour constants for white, cyan, red and yellow.
- Sub-module frame_tick_gen: 2-flop synchroniser plus rising-edge detector producing frame_tick.
- FSM, counters and overlay mux stay in msg_screen_ctrl.

Test Plan:
- Reset, then 5 frame_clk rises with no keys -> state TITLE; is_press_start = 1 gives overlay_on = 1 with blink_on = 1; game_run = 0.
- Hold TITLE for 30 ticks -> blink_on = 0; is_press_start = 1 gives overlay_on = 0; is_galaga = 1 still gives RGB FF/FF/FF. After 60 ticks blink_on = 1.
- start_key, then boss_wave pulse -> BOSS. is_boss gives FF/00/00 and game_run = 1. After exactly 120 ticks -> PLAY; after 119 ticks still BOSS.
- PLAY with player_dead and all_cleared in the same cycle -> GAMEOVER. start_key at tick 59 is ignored; start_key at tick 60 -> TITLE.
- all_cleared in PLAY, no keys -> WIN. is_you_win gives FF/FF/00. Returns to TITLE on tick 300.
- Reset_n low for 1 cycle while in BOSS at tick 50 -> next cycle TITLE, frame_cnt = 0, blink_on = 1, game_run = 0.
